data_output: RTL and testbench

Transmit-side counterpart of the serial sample receiver. Buffers 24-bit parallel sample words from the fabric in a 64-entry FIFO and shifts them LSB-first onto `serial`, one bit per `rpi_clk` period. Raises `rpi_interrupt` while the buffer is at or below a low-water mark, so the Raspberry Pi keeps clocking data out without starving the fabric side. Sits between the sample pipeline and the RPi GPIO pins.

---
 rtl/data_output_pkg.sv | 14 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/data_output.sv | 173 +++++++++++++++++
 tb/tb_data_output.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_output_pkg.sv
// Shared constants and FSM state type for the data_output serializer.
package data_output_pkg;

    localparam int WORD_W    = 24;
    localparam int DEPTH     = 64;
    localparam int LOW_WATER = 32;
    localparam int FILL_W    = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word and a separate occupancy counter.
module sync_fifo #(
    parameter int WORD_W = 24,
    parameter int DEPTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WORD_W-1:0]            push_data,
    input  logic                         pop,
    output logic [WORD_W-1:0]            pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full is decided before this cycle's pop, so a pop never frees room for a same-cycle push.
    assign full     = (fill == FILL_W'(DEPTH));
    assign empty    = (fill == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and fill define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/data_output.sv
// FIFO-buffered LSB-first serializer shifted by the asynchronous RPi bit clock.
// Optional sticky underrun flag enabled by defining DATA_OUTPUT_UNDERRUN_EN.
module data_output
    import data_output_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              enable,
    input  logic              rpi_clk,
    output logic              serial,
    output logic              rpi_interrupt,
    output logic [FILL_W-1:0] fill,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic              rpi_meta;
    logic              rpi_sync;
    logic              rpi_prev;
    logic              fall;

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [CNT_W-1:0]  bit_nxt;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_d;
    logic              serial_d;

    logic [WORD_W-1:0] head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FILL_W-1:0] fill_next;
    logic              underrun_event;

    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;

    sync_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .fill      (fill)
    );

    // rpi_meta may go metastable; only rpi_sync and rpi_prev feed logic.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpi_meta <= 1'b0;
            rpi_sync <= 1'b0;
            rpi_prev <= 1'b0;
        end else begin
            rpi_meta <= rpi_clk;
            rpi_sync <= rpi_meta;
            rpi_prev <= rpi_sync;
        end
    end

    assign fall    = rpi_prev && !rpi_sync;
    assign bit_nxt = bit_cnt_q + CNT_W'(1);

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        serial_d       = serial;
        pop            = 1'b0;
        underrun_event = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d = 1'b0;
                if (enable && !empty) begin
                    pop       = 1'b1;
                    shreg_d   = head;
                    serial_d  = head[0];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_nxt;
                        serial_d  = shreg_q[bit_nxt];
                    end else if (enable && !empty) begin
                        pop       = 1'b1;
                        shreg_d   = head;
                        serial_d  = head[0];
                        bit_cnt_d = '0;
                    end else begin
                        // A word always completes; enable only gates starting the next one.
                        state_d        = IDLE;
                        serial_d       = 1'b0;
                        underrun_event = enable;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            serial    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            serial    <= serial_d;
        end
    end

    // Interrupt tracks the occupancy fill is about to take, so both update on the same edge.
    always_comb begin
        fill_next = fill;
        if (push && !pop) begin
            fill_next = fill + FILL_W'(1);
        end else if (pop && !push) begin
            fill_next = fill - FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpi_interrupt <= 1'b1;
        end else begin
            rpi_interrupt <= (fill_next <= FILL_W'(LOW_WATER));
        end
    end

`ifdef DATA_OUTPUT_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end else if (underrun_event) begin
            underrun <= 1'b1;
        end
    end
`else
    logic unused_underrun;

    assign underrun        = 1'b0;
    assign unused_underrun = underrun_clr ^ underrun_event;
`endif

endmodule

// File: tb/tb_data_output.sv
// Directed self-checking bench for data_output; the RPi bit clock is emulated at 6+6 clk periods.
module tb_data_output;
    import data_output_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              enable;
    logic              rpi_clk;
    logic              serial;
    logic              rpi_interrupt;
    logic [FILL_W-1:0] fill;
    logic              underrun;
    logic              underrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    data_output dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .enable        (enable),
        .rpi_clk       (rpi_clk),
        .serial        (serial),
        .rpi_interrupt (rpi_interrupt),
        .fill          (fill),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [WORD_W-1:0] val(input int i);
        return 24'h10F00F ^ WORD_W'(i * 24'h03A5C1);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One RPi bit period, entered and left on a clk falling edge; serial is read at the rising edge.
    task automatic rpi_bit(output logic b);
        rpi_clk = 1'b1;
        b = serial;
        repeat (6) @(negedge clk);
        rpi_clk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic shift_bits(input int n, output logic [63:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            rpi_bit(b);
            w[i] = b;
        end
    endtask

    logic [63:0] word;
    logic        bit_v;
    logic        exp_ur;

    initial begin
        rst          = 1'b1;
        wr_data      = '0;
        wr_valid     = 1'b0;
        enable       = 1'b0;
        rpi_clk      = 1'b0;
        underrun_clr = 1'b0;
`ifdef DATA_OUTPUT_UNDERRUN_EN
        exp_ur = 1'b1;
`else
        exp_ur = 1'b0;
`endif

        // Reset state
        do_reset();
        check("rst_fill",      64'(fill),          64'd0);
        check("rst_wr_ready",  64'(wr_ready),      64'd1);
        check("rst_serial",    64'(serial),        64'd0);
        check("rst_interrupt", 64'(rpi_interrupt), 64'd1);
        check("rst_underrun",  64'(underrun),      64'd0);
        check("rst_state",     64'(dut.state_q),   64'(IDLE));

        // Single word, enable dropped after the pop: word still completes
        enable   = 1'b1;
        wr_data  = 24'hA5C30F;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("one_fill_after_push", 64'(fill), 64'd1);
        @(negedge clk);
        enable = 1'b0;
        check("one_fill_after_pop", 64'(fill),        64'd0);
        check("one_state_shift",    64'(dut.state_q), 64'(SHIFT));
        check("one_first_bit",      64'(serial),      64'd1);
        shift_bits(24, word);
        check("one_word",         word,               64'h A5C30F);
        check("one_serial_after", 64'(serial),        64'd0);
        check("one_state_after",  64'(dut.state_q),   64'(IDLE));
        check("one_no_underrun",  64'(underrun),      64'd0);

        // Fill to 64: low-water edge at 32/33, full, dropped 65th push
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data  = val(i);
            wr_valid = 1'b1;
            @(negedge clk);
            if (i == 31) begin
                check("lw_fill_32", 64'(fill),          64'd32);
                check("lw_irq_32",  64'(rpi_interrupt), 64'd1);
            end
            if (i == 32) begin
                check("lw_fill_33", 64'(fill),          64'd33);
                check("lw_irq_33",  64'(rpi_interrupt), 64'd0);
            end
        end
        check("full_fill",     64'(fill),          64'd64);
        check("full_wr_ready", 64'(wr_ready),      64'd0);
        check("full_irq",      64'(rpi_interrupt), 64'd0);
        wr_data = 24'hDEAD00;
        @(negedge clk);
        check("full_drop_65th", 64'(fill), 64'd64);
        enable = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        enable   = 1'b0;
        check("pop_push_blocked",  64'(fill),     64'd63);
        check("pop_wr_ready",      64'(wr_ready), 64'd1);
        shift_bits(24, word);
        check("full_word0", word, 64'(val(0)));
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        shift_bits(24, word);
        check("full_word1", word, 64'(val(1)));
        check("full_fill_62", 64'(fill), 64'd62);

        // Back-to-back words with no gap bit
        do_reset();
        enable   = 1'b1;
        wr_data  = 24'h000001;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_data = 24'h800000;
        @(negedge clk);
        wr_valid = 1'b0;
        check("b2b_fill_push_pop", 64'(fill), 64'd1);
        word = '0;
        for (int i = 0; i < 48; i++) begin
            if (i == 24) begin
                check("b2b_second_popped", 64'(fill), 64'd0);
            end
            if (i == 30) begin
                enable = 1'b0;
            end
            rpi_bit(bit_v);
            word[i] = bit_v;
        end
        check("b2b_48_bits",   word,             64'h8000_0000_0001);
        check("b2b_serial",    64'(serial),      64'd0);
        check("b2b_state",     64'(dut.state_q), 64'(IDLE));
        check("b2b_underrun",  64'(underrun),    64'd0);

        // Underrun: enable held with only one word queued
        do_reset();
        enable   = 1'b1;
        wr_data  = 24'h5A5A5A;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        shift_bits(30, word);
        check("ur_word",     word,             64'h5A5A5A);
        check("ur_flag",     64'(underrun),    64'(exp_ur));
        check("ur_serial",   64'(serial),      64'd0);
        check("ur_state",    64'(dut.state_q), 64'(IDLE));
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("ur_cleared", 64'(underrun), 64'd0);
        enable = 1'b0;

        // Reset mid-word with queued data
        do_reset();
        enable   = 1'b1;
        wr_data  = 24'hFFFFFF;
        wr_valid = 1'b1;
        repeat (5) @(negedge clk);
        wr_valid = 1'b0;
        check("mid_fill_4", 64'(fill), 64'd4);
        shift_bits(10, word);
        check("mid_bits",   word,         64'h3FF);
        check("mid_bit10",  64'(serial),  64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_fill",     64'(fill),          64'd0);
        check("mid_rst_serial",   64'(serial),        64'd0);
        check("mid_rst_state",    64'(dut.state_q),   64'(IDLE));
        check("mid_rst_irq",      64'(rpi_interrupt), 64'd1);
        check("mid_rst_wr_ready", 64'(wr_ready),      64'd1);
        rst    = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_post_fill",   64'(fill),   64'd0);
        check("mid_post_serial", 64'(serial), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
